picomips_run_ctrl: RTL and testbench

//  Run-control sequencer for the picoMIPS CPU on the DE0 board. Replaces the free-running slow clock:
//  the CPU runs on clk and advances only when cpu_en is high. Provides free-run at a divided rate,

---
 rtl/picomips_run_ctrl_if.sv | 39 +++
 rtl/picomips_run_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_picomips_run_ctrl.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/picomips_run_ctrl_if.sv
// CPU-side signal bundle for the picoMIPS run-control sequencer.
// The master modport is the sequencer; the slave modport is the CPU/board side.
interface picomips_run_ctrl_if #(
  parameter int unsigned PC_W  = 8,
  parameter int unsigned CNT_W = 16
);

  logic             cpu_en;
  logic             cpu_rst;
  logic [1:0]       state;
  logic [CNT_W-1:0] inst_cnt;
  logic             cpu_halt;
  logic [PC_W-1:0]  pc;
  logic             bp_en;
  logic [PC_W-1:0]  bp_addr;

  modport master (
    output cpu_en,
    output cpu_rst,
    output state,
    output inst_cnt,
    input  cpu_halt,
    input  pc,
    input  bp_en,
    input  bp_addr
  );

  modport slave (
    input  cpu_en,
    input  cpu_rst,
    input  state,
    input  inst_cnt,
    output cpu_halt,
    output pc,
    output bp_en,
    output bp_addr
  );

endinterface

// File: rtl/picomips_run_ctrl.sv
// Run-control sequencer for the picoMIPS CPU: post-reset hold, divided free-run,
// debounced single-step, PC breakpoint and halt handling, issued-enable counter.
module picomips_run_ctrl #(
  parameter int unsigned DIV        = 5_000_000,
  parameter int unsigned DEB_CYCLES = 500_000,
  parameter int unsigned RST_CYCLES = 4,
  parameter int unsigned PC_W       = 8,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run_sw,
  input  logic                step_n,
  picomips_run_ctrl_if.master bus
);

  localparam int unsigned PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int unsigned RST_W = $clog2(RST_CYCLES + 1);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    StRst  = 2'b00,
    StRun  = 2'b01,
    StStep = 2'b10,
    StHalt = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    CauseNone = 2'b00,
    CauseCpu  = 2'b01,
    CauseBp   = 2'b10
  } cause_e;

  // Synchronised switch/key levels.
  logic run_meta, run_sync;
  logic step_meta, step_sync;

  // Debouncer: accepted key level and consecutive-disagreement counter.
  logic             key_down_q, key_down_d;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic             step_req;
  logic             step_go_q;

  // Sequencer state.
  state_e           state_q, state_d;
  cause_e           cause_q, cause_d;
  logic [RST_W-1:0] rst_cnt_q, rst_cnt_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             en;
  logic             want;
  logic             bp_hit;
  logic [PC_W-1:0]  pc;
  logic [PC_W-1:0]  bp_addr;

  assign pc      = bus.pc;
  assign bp_addr = bus.bp_addr;
  assign bp_hit  = bus.bp_en && (pc == bp_addr);

  // Two-flop synchronisers; reset to "run off" and "key released".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_meta  <= 1'b0;
      run_sync  <= 1'b0;
      step_meta <= 1'b1;
      step_sync <= 1'b1;
    end else begin
      run_meta  <= run_sw;
      run_sync  <= run_meta;
      step_meta <= step_n;
      step_sync <= step_meta;
    end
  end

  // Accept a new key level only after DEB_CYCLES consecutive disagreeing samples.
  always_comb begin
    key_down_d = key_down_q;
    deb_cnt_d  = '0;
    step_req   = 1'b0;
    if (step_sync == key_down_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        key_down_d = ~key_down_q;
        step_req   = ~key_down_q;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
  end

  // Debouncer state and the delayed step strobe (only armed where steps are honoured).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_down_q <= 1'b0;
      deb_cnt_q  <= '0;
      step_go_q  <= 1'b0;
    end else begin
      key_down_q <= key_down_d;
      deb_cnt_q  <= deb_cnt_d;
      step_go_q  <= step_req && ((state_q == StStep) || (state_q == StHalt));
    end
  end

  // Next-state, enable issue and prescaler; halt checks take priority over issue.
  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    rst_cnt_d = rst_cnt_q;
    pre_d     = '0;
    en        = 1'b0;
    want      = 1'b0;
    unique case (state_q)
      StRst: begin
        if (rst_cnt_q == RST_LAST) begin
          state_d = run_sync ? StRun : StStep;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      StRun, StStep: begin
        want = (state_q == StRun) ? (pre_q == PRE_LAST) : step_go_q;
        if (bus.cpu_halt) begin
          state_d = StHalt;
          cause_d = CauseCpu;
        end else if (want && bp_hit) begin
          state_d = StHalt;
          cause_d = CauseBp;
        end else begin
          en = want;
          if ((state_q == StRun) && !run_sync) begin
            state_d = StStep;
          end else if ((state_q == StStep) && run_sync) begin
            state_d = StRun;
          end
        end
        if ((state_q == StRun) && (state_d == StRun)) begin
          pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
        end
      end
      StHalt: begin
        // Resume from a breakpoint: one pulse with the compare bypassed, then leave.
        if ((cause_q == CauseBp) && step_go_q) begin
          en      = 1'b1;
          cause_d = CauseNone;
          state_d = run_sync ? StRun : StStep;
        end
      end
      default: begin
        state_d = StRst;
      end
    endcase
  end

  // Saturating count of issued enables.
  always_comb begin
    cnt_d = cnt_q;
    if (en && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Sequencer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StRst;
      cause_q   <= CauseNone;
      rst_cnt_q <= '0;
      pre_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      cause_q   <= cause_d;
      rst_cnt_q <= rst_cnt_d;
      pre_q     <= pre_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.cpu_en   = en;
  assign bus.cpu_rst  = (state_q == StRst);
  assign bus.state    = state_q;
  assign bus.inst_cnt = cnt_q;

endmodule

// File: tb/tb_picomips_run_ctrl.sv
// Directed bench for picomips_run_ctrl: expectations are queued when a step is
// driven and popped/compared when the DUT outputs are sampled.
module tb_picomips_run_ctrl;

  logic clk;
  logic rst_n_a, run_sw_a, step_n_a;
  logic rst_n_b, run_sw_b, step_n_b;

  int unsigned n_vec  = 0;
  int unsigned n_fail = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];

  picomips_run_ctrl_if #(.PC_W(8), .CNT_W(16)) bus_a ();
  picomips_run_ctrl_if #(.PC_W(8), .CNT_W(4))  bus_b ();

  picomips_run_ctrl #(
    .DIV(4), .DEB_CYCLES(8), .RST_CYCLES(4), .PC_W(8), .CNT_W(16)
  ) dut_a (
    .clk(clk), .rst_n(rst_n_a), .run_sw(run_sw_a), .step_n(step_n_a), .bus(bus_a.master)
  );

  picomips_run_ctrl #(
    .DIV(2), .DEB_CYCLES(8), .RST_CYCLES(4), .PC_W(8), .CNT_W(4)
  ) dut_b (
    .clk(clk), .rst_n(rst_n_b), .run_sw(run_sw_b), .step_n(step_n_b), .bus(bus_b.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expect_val(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic observe(input logic [31:0] obs);
    exp_t e;
    n_vec++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $error("FAIL sb_empty: got 0x%0h, expected a queued value", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s: got 0x%0h, expected 0x%0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic exp_snap(input string t, input logic en, input logic rst, input logic [1:0] st,
                          input logic [31:0] cnt);
    expect_val({t, ".cpu_en"}, 32'(en));
    expect_val({t, ".cpu_rst"}, 32'(rst));
    expect_val({t, ".state"}, 32'(st));
    expect_val({t, ".inst_cnt"}, cnt);
  endtask

  task automatic obs_snap(input logic en, input logic rst, input logic [1:0] st,
                          input logic [31:0] cnt);
    observe(32'(en));
    observe(32'(rst));
    observe(32'(st));
    observe(cnt);
  endtask

  task automatic obs_a();
    obs_snap(bus_a.cpu_en, bus_a.cpu_rst, bus_a.state, 32'(bus_a.inst_cnt));
  endtask

  task automatic obs_b();
    obs_snap(bus_b.cpu_en, bus_b.cpu_rst, bus_b.state, 32'(bus_b.inst_cnt));
  endtask

  // Invariants: no enable during CPU reset, never two enables back to back.
  logic prev_en_a = 1'b0;
  logic prev_en_b = 1'b0;
  always @(negedge clk) begin
    #3;
    n_vec++;
    assert (!(bus_a.cpu_en && (bus_a.cpu_rst || prev_en_a))) else begin
      n_fail++;
      $error("FAIL inv_a: got cpu_en=%0b cpu_rst=%0b prev_en=%0b, expected isolated enable",
             bus_a.cpu_en, bus_a.cpu_rst, prev_en_a);
    end
    n_vec++;
    assert (!(bus_b.cpu_en && (bus_b.cpu_rst || prev_en_b))) else begin
      n_fail++;
      $error("FAIL inv_b: got cpu_en=%0b cpu_rst=%0b prev_en=%0b, expected isolated enable",
             bus_b.cpu_en, bus_b.cpu_rst, prev_en_b);
    end
    prev_en_a = bus_a.cpu_en;
    prev_en_b = bus_b.cpu_en;
  end

  initial begin
    logic        en_e;
    logic [31:0] exp_cnt;
    logic [31:0] cnt_b;
    int          pulses;

    rst_n_a = 1'b0; run_sw_a = 1'b1; step_n_a = 1'b1;
    rst_n_b = 1'b0; run_sw_b = 1'b1; step_n_b = 1'b1;
    bus_a.cpu_halt = 1'b0; bus_a.pc = 8'h00; bus_a.bp_en = 1'b0; bus_a.bp_addr = 8'h00;
    bus_b.cpu_halt = 1'b0; bus_b.pc = 8'h00; bus_b.bp_en = 1'b0; bus_b.bp_addr = 8'h00;

    repeat (3) @(negedge clk);
    exp_snap("reset", 1'b0, 1'b1, 2'b00, 32'd0);
    #1; obs_a();

    // Post-reset hold then free-run at DIV=4.
    rst_n_a = 1'b1;
    exp_cnt = 32'd0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      en_e = (k >= 4) && (((k - 4) % 4) == 3);
      exp_snap($sformatf("run%0d", k), en_e, (k < 4), (k < 4) ? 2'b00 : 2'b01, exp_cnt);
      #1; obs_a();
      if (en_e) exp_cnt++;
    end

    // Breakpoint at 0x05: enable at pc=5 suppressed, then HALT.
    bus_a.bp_en = 1'b1; bus_a.bp_addr = 8'h05; bus_a.pc = 8'h04;
    for (int k = 17; k <= 23; k++) begin
      @(negedge clk);
      if (k == 20) bus_a.pc = 8'h05;
      en_e = (k == 19);
      exp_snap($sformatf("bp%0d", k), en_e, 1'b0, 2'b01, exp_cnt);
      #1; obs_a();
      if (en_e) exp_cnt++;
    end
    @(negedge clk);
    step_n_a = 1'b0;
    exp_snap("bp_halt", 1'b0, 1'b0, 2'b11, exp_cnt);
    #1; obs_a();
    // Key press resumes with one bypassed enable, then back to RUN.
    for (int k = 25; k <= 34; k++) begin
      @(negedge clk);
      en_e = (k == 34);
      exp_snap($sformatf("bpstep%0d", k), en_e, 1'b0, 2'b11, exp_cnt);
      #1; obs_a();
      if (en_e) exp_cnt++;
    end
    run_sw_a = 1'b0; step_n_a = 1'b1; bus_a.bp_en = 1'b0; bus_a.pc = 8'h06;
    @(negedge clk);
    exp_snap("bp_resume", 1'b0, 1'b0, 2'b01, exp_cnt);
    #1; obs_a();
    repeat (12) @(negedge clk);
    exp_snap("to_step", 1'b0, 1'b0, 2'b10, exp_cnt);
    #1; obs_a();

    // Bouncy single-step press: exactly one enable.
    pulses = 0;
    for (int i = 0; i < 54; i++) begin
      @(negedge clk);
      step_n_a = (i < 3) ? 1'b0 : (i == 3) ? 1'b1 : (i < 24) ? 1'b0 : 1'b1;
      #1;
      if (bus_a.cpu_en) pulses++;
    end
    expect_val("step_pulses", 32'd1);
    observe(32'(pulses));
    exp_cnt++;
    exp_snap("step_end", 1'b0, 1'b0, 2'b10, exp_cnt);
    obs_a();

    // CPU halt in RUN: suppresses the due enable, terminal until reset.
    @(negedge clk);
    run_sw_a = 1'b1;
    repeat (3) @(negedge clk);
    exp_snap("halt_run", 1'b0, 1'b0, 2'b01, exp_cnt);
    #1; obs_a();
    repeat (3) @(negedge clk);
    bus_a.cpu_halt = 1'b1;
    exp_snap("halt_slot", 1'b0, 1'b0, 2'b01, exp_cnt);
    #1; obs_a();
    @(negedge clk);
    exp_snap("halt_entered", 1'b0, 1'b0, 2'b11, exp_cnt);
    #1; obs_a();
    pulses = 0;
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 24; i++) begin
        @(negedge clk);
        step_n_a = (i < 12) ? 1'b0 : 1'b1;
        run_sw_a = (p == 1) ? 1'b0 : 1'b1;
        #1;
        if (bus_a.cpu_en) pulses++;
      end
    end
    expect_val("halt_pulses", 32'd0);
    observe(32'(pulses));
    exp_snap("halt_hold", 1'b0, 1'b0, 2'b11, exp_cnt);
    obs_a();
    @(negedge clk);
    #2;
    rst_n_a = 1'b0;
    exp_snap("halt_reset", 1'b0, 1'b1, 2'b00, 32'd0);
    #1; obs_a();

    // Asynchronous reset mid-prescale in RUN.
    bus_a.cpu_halt = 1'b0;
    run_sw_a = 1'b1;
    @(negedge clk);
    rst_n_a = 1'b1;
    exp_cnt = 32'd0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      en_e = (k >= 4) && (((k - 4) % 4) == 3);
      exp_snap($sformatf("rerun%0d", k), en_e, (k < 4), (k < 4) ? 2'b00 : 2'b01, exp_cnt);
      #1; obs_a();
      if (en_e) exp_cnt++;
    end
    #2;
    rst_n_a = 1'b0;
    exp_snap("async_rst", 1'b0, 1'b1, 2'b00, 32'd0);
    #1; obs_a();

    // 4-bit counter at DIV=2 saturates while enables keep coming.
    @(negedge clk);
    rst_n_b = 1'b1;
    cnt_b = 32'd0;
    for (int k = 1; k <= 44; k++) begin
      @(negedge clk);
      en_e = (k >= 4) && (((k - 4) % 2) == 1);
      exp_snap($sformatf("sat%0d", k), en_e, (k < 4), (k < 4) ? 2'b00 : 2'b01, cnt_b);
      #1; obs_b();
      if (en_e && (cnt_b < 32'd15)) cnt_b++;
    end
    expect_val("sat_final", 32'hF);
    observe(32'(bus_b.inst_cnt));

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
